// File: rtl/fpu_pkg.sv
// fpu_pkg: constants shared by the FPU dispatch front end.
//   - FUNCT5_* : funct5 encodings (instr[31:27]) of the supported FP ops
//   - U_*      : unit slot indices on the u_* buses, NUNIT slots in total
//   - S_*      : dispatch FSM state encoding
package fpu_pkg;

  localparam int DATA_W = 32;
  localparam int NUNIT  = 6;

  // funct5 encodings
  localparam logic [4:0] FUNCT5_FADD   = 5'b00000;
  localparam logic [4:0] FUNCT5_FSUB   = 5'b00001;
  localparam logic [4:0] FUNCT5_FMUL   = 5'b00010;
  localparam logic [4:0] FUNCT5_FDIV   = 5'b00011;
  localparam logic [4:0] FUNCT5_FSGNJ  = 5'b00100;
  localparam logic [4:0] FUNCT5_FMINMAX= 5'b00101;
  localparam logic [4:0] FUNCT5_FSQRT  = 5'b01011;
  localparam logic [4:0] FUNCT5_FCMP   = 5'b10100;
  localparam logic [4:0] FUNCT5_FCVTWS = 5'b11000;
  localparam logic [4:0] FUNCT5_FCVTSW = 5'b11010;
  localparam logic [4:0] FUNCT5_FMVXW  = 5'b11100;
  localparam logic [4:0] FUNCT5_FMVWX  = 5'b11110;

  // unit slot indices
  localparam logic [2:0] U_ADD  = 3'd0;
  localparam logic [2:0] U_MUL  = 3'd1;
  localparam logic [2:0] U_DIV  = 3'd2;
  localparam logic [2:0] U_SQRT = 3'd3;
  localparam logic [2:0] U_COMP = 3'd4;
  localparam logic [2:0] U_MISC = 3'd5;

  // dispatch FSM states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

endpackage

// File: rtl/fpu_decode.sv
// fpu_decode: combinational funct5 -> unit slot decoder.
//   funct5 : instr[31:27] of the FP op
//   legal  : funct5 maps to an implemented unit
//   idx    : unit slot index (0 when illegal)
module fpu_decode
  import fpu_pkg::*;
(
  input  logic [4:0] funct5,
  output logic       legal,
  output logic [2:0] idx
);

  always_comb begin
    legal = 1'b1;
    idx   = U_ADD;
    case (funct5)
      FUNCT5_FADD, FUNCT5_FSUB:           idx = U_ADD;
      FUNCT5_FMUL:                        idx = U_MUL;
      FUNCT5_FDIV:                        idx = U_DIV;
      FUNCT5_FSQRT:                       idx = U_SQRT;
      FUNCT5_FCMP:                        idx = U_COMP;
      FUNCT5_FSGNJ, FUNCT5_FMINMAX,
      FUNCT5_FCVTWS, FUNCT5_FCVTSW,
      FUNCT5_FMVXW, FUNCT5_FMVWX:         idx = U_MISC;
      default: begin
        legal = 1'b0;
        idx   = U_ADD;
      end
    endcase
  end

endmodule

// File: rtl/fpu_dispatch.sv
// fpu_dispatch: FPU front end between the core execute stage and the FP units.
// Takes one op at a time, latches operands, issues to the decoded unit with an
// order/accepted/done handshake, and returns the result with a one-cycle done.
//   clk, rstn            : clock, asynchronous active-low reset
//   order/accepted       : core request / request taken this cycle
//   rs1, rs2, funct5, func3 : core operands and op select
//   done, rd, err        : completion pulse, result (held), error flag
//   busy                 : an op is in flight
//   u_order/u_accepted/u_done : per-unit handshake (one-hot order)
//   u_rs1, u_rs2, u_func3, u_funct5 : latched operands broadcast to units
//   u_rd                 : unit results, slot i at [32i+31:32i]
module fpu_dispatch #(
  parameter int TIMEOUT = 255,
  parameter int NUNIT   = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                order,
  output logic                accepted,
  output logic                done,
  input  logic [31:0]         rs1,
  input  logic [31:0]         rs2,
  input  logic [4:0]          funct5,
  input  logic [2:0]          func3,
  output logic [31:0]         rd,
  output logic                err,
  output logic                busy,
  output logic [NUNIT-1:0]    u_order,
  input  logic [NUNIT-1:0]    u_accepted,
  input  logic [NUNIT-1:0]    u_done,
  output logic [31:0]         u_rs1,
  output logic [31:0]         u_rs2,
  output logic [2:0]          u_func3,
  output logic [4:0]          u_funct5,
  input  logic [32*NUNIT-1:0] u_rd
);
  import fpu_pkg::*;

  // Width stays at least 1 so TIMEOUT=0 (watchdog off) still elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The counter is compared one early so err lands in the cycle it reaches TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [2:0]       idx_q;
  logic [CNT_W-1:0] wd_cnt;
  logic [31:0]      rd_q;
  logic             err_q;

  logic             dec_legal;
  logic [2:0]       dec_idx;
  logic             sel_acc;
  logic             sel_done;
  logic [31:0]      sel_rd;

  fpu_decode u_decode (
    .funct5 (funct5),
    .legal  (dec_legal),
    .idx    (dec_idx)
  );

  // Pick out only the addressed unit's strobes and result; other slots are ignored.
  always_comb begin
    sel_acc  = 1'b0;
    sel_done = 1'b0;
    sel_rd   = '0;
    u_order  = '0;
    for (int i = 0; i < NUNIT; i++) begin
      if (idx_q == i[2:0]) begin
        sel_acc    = u_accepted[i];
        sel_done   = u_done[i];
        sel_rd     = u_rd[i*32 +: 32];
        u_order[i] = (state == S_ISSUE);
      end
    end
  end

  // rstn gating keeps accepted low while reset is asserted even if order is high.
  assign accepted = rstn && order && (state == S_IDLE);
  assign done     = (state == S_RESP);
  assign busy     = (state != S_IDLE);
  assign rd       = rd_q;
  assign err      = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      idx_q    <= '0;
      wd_cnt   <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      u_rs1    <= '0;
      u_rs2    <= '0;
      u_func3  <= '0;
      u_funct5 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (order) begin
            u_rs1    <= rs1;
            u_rs2    <= rs2;
            u_func3  <= func3;
            u_funct5 <= funct5;
            idx_q    <= dec_idx;
            if (dec_legal) begin
              state <= S_ISSUE;
            end else begin
              rd_q  <= '0;
              err_q <= 1'b1;
              state <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          if (sel_acc) begin
            // Combinational units complete in the accept cycle.
            if (sel_done) begin
              rd_q  <= sel_rd;
              err_q <= 1'b0;
              state <= S_RESP;
            end else begin
              wd_cnt <= '0;
              state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A real result wins over a timeout landing in the same cycle.
          if (sel_done) begin
            rd_q  <= sel_rd;
            err_q <= 1'b0;
            state <= S_RESP;
          end else if ((TIMEOUT != 0) && (wd_cnt == CNT_LAST)) begin
            rd_q  <= '0;
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dispatch.sv
// tb_fpu_dispatch: directed self-checking bench for fpu_dispatch (TIMEOUT=4).
module tb_fpu_dispatch;

  localparam int NU = 6;

  logic            clk;
  logic            rstn;
  logic            order;
  logic            accepted;
  logic            done;
  logic [31:0]     rs1, rs2;
  logic [4:0]      funct5;
  logic [2:0]      func3;
  logic [31:0]     rd;
  logic            err;
  logic            busy;
  logic [NU-1:0]   u_order;
  logic [NU-1:0]   u_accepted;
  logic [NU-1:0]   u_done;
  logic [31:0]     u_rs1, u_rs2;
  logic [2:0]      u_func3;
  logic [4:0]      u_funct5;
  logic [32*NU-1:0] u_rd;

  int total = 0;
  int bad   = 0;

  fpu_dispatch #(.TIMEOUT(4), .NUNIT(NU)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .order      (order),
    .accepted   (accepted),
    .done       (done),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct5     (funct5),
    .func3      (func3),
    .rd         (rd),
    .err        (err),
    .busy       (busy),
    .u_order    (u_order),
    .u_accepted (u_accepted),
    .u_done     (u_done),
    .u_rs1      (u_rs1),
    .u_rs2      (u_rs2),
    .u_func3    (u_func3),
    .u_funct5   (u_funct5),
    .u_rd       (u_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [4:0] f5, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b);
    order  = 1'b1;
    funct5 = f5;
    func3  = f3;
    rs1    = a;
    rs2    = b;
  endtask

  task automatic clr_units();
    u_accepted = '0;
    u_done     = '0;
    u_rd       = '0;
  endtask

  task automatic set_unit(input int i, input logic acc, input logic dn, input logic [31:0] v);
    u_accepted[i]    = acc;
    u_done[i]        = dn;
    u_rd[i*32 +: 32] = v;
  endtask

  initial begin
    rstn = 1'b0;
    req(5'b10100, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    clr_units();
    #2;
    // reset state, order held high during reset
    chk("rst_accepted", accepted, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", rd, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_uorder", u_order, 0);
    chk("rst_urs1", u_rs1, 0);
    chk("rst_urs2", u_rs2, 0);
    chk("rst_ufunct5", u_funct5, 0);
    order = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // fle via combinational comp unit: done at cycle 2
    step(); req(5'b10100, 3'b000, 32'h3F80_0000, 32'h4000_0000); #1;
    chk("fle_acc", accepted, 1);
    chk("fle_busy0", busy, 0);
    step(); order = 1'b0; #1;
    chk("fle_uorder", u_order, 6'b010000);
    chk("fle_busy1", busy, 1);
    chk("fle_urs1", u_rs1, 32'h3F80_0000);
    chk("fle_urs2", u_rs2, 32'h4000_0000);
    chk("fle_ufunct5", u_funct5, 5'b10100);
    chk("fle_ufunc3", u_func3, 3'b000);
    chk("fle_done1", done, 0);
    set_unit(4, 1'b1, 1'b1, 32'h0000_0001);
    step(); clr_units(); #1;
    chk("fle_done2", done, 1);
    chk("fle_rd", rd, 32'h0000_0001);
    chk("fle_err", err, 0);
    chk("fle_uorder2", u_order, 0);
    step(); #1;
    chk("fle_done3", done, 0);
    chk("fle_rdhold", rd, 32'h0000_0001);
    chk("fle_busy3", busy, 0);

    // fmul: 2 stall cycles, done 3 cycles after accept -> done at cycle 7
    step(); req(5'b00010, 3'b000, 32'h4000_0000, 32'h4040_0000); #1;
    chk("mul_acc", accepted, 1);
    step(); order = 1'b0; #1;
    chk("mul_uorder1", u_order, 6'b000010);
    // foreign strobes and a bare done on our unit must be ignored
    set_unit(0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    u_done[1] = 1'b1;
    step(); clr_units(); #1;
    chk("mul_uorder2", u_order, 6'b000010);
    chk("mul_done2", done, 0);
    step(); #1;
    chk("mul_uorder3", u_order, 6'b000010);
    set_unit(1, 1'b1, 1'b0, 32'h0);
    step(); clr_units(); #1;
    chk("mul_uorder4", u_order, 0);
    chk("mul_busy4", busy, 1);
    chk("mul_done4", done, 0);
    step(); #1;
    chk("mul_done5", done, 0);
    step(); #1;
    chk("mul_done6", done, 0);
    set_unit(1, 1'b0, 1'b1, 32'h40C0_0000);
    step(); clr_units(); #1;
    chk("mul_done7", done, 1);
    chk("mul_rd", rd, 32'h40C0_0000);
    chk("mul_err", err, 0);

    // fdiv never done, TIMEOUT=4 -> err done at cycle 6
    step(); #1;
    step(); req(5'b00011, 3'b001, 32'h4110_0000, 32'h4040_0000); #1;
    chk("to_acc", accepted, 1);
    step(); order = 1'b0; #1;
    chk("to_uorder", u_order, 6'b000100);
    set_unit(2, 1'b1, 1'b0, 32'h0);
    step(); clr_units(); #1;
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("to_nodone_c%0d", c), done, 0);
      if (c < 5) step(); else #0;
    end
    chk("to_rdhold", rd, 32'h40C0_0000);
    step(); #1;
    chk("to_done6", done, 1);
    chk("to_err", err, 1);
    chk("to_rd", rd, 0);

    // same, but u_done lands in the timeout cycle -> real result wins
    step(); #1;
    step(); req(5'b00011, 3'b000, 32'h4000_0000, 32'h3F80_0000); #1;
    step(); order = 1'b0; #1;
    set_unit(2, 1'b1, 1'b0, 32'h0);
    step(); clr_units(); #1;   // cycle 2
    step(); #1;                // cycle 3
    step(); #1;                // cycle 4
    step(); #1;                // cycle 5
    chk("tod_done5", done, 0);
    set_unit(2, 1'b0, 1'b1, 32'h3FB5_04F3);
    step(); clr_units(); #1;   // cycle 6
    chk("tod_done6", done, 1);
    chk("tod_err", err, 0);
    chk("tod_rd", rd, 32'h3FB5_04F3);

    // illegal funct5 -> done at cycle 1 with err
    step(); #1;
    step(); req(5'b01111, 3'b000, 32'h1111_1111, 32'h2222_2222); #1;
    chk("ill_acc", accepted, 1);
    chk("ill_uorder0", u_order, 0);
    step(); order = 1'b0; #1;
    chk("ill_done", done, 1);
    chk("ill_err", err, 1);
    chk("ill_rd", rd, 0);
    chk("ill_uorder1", u_order, 0);
    step(); #1;
    chk("ill_done2", done, 0);

    // new order held through busy/RESP is taken only in the following IDLE
    step(); req(5'b10100, 3'b010, 32'hAAAA_0001, 32'hAAAA_0002); #1;
    step(); req(5'b00000, 3'b001, 32'h1111_1111, 32'h2222_2222); #1;
    chk("bb_acc_issue", accepted, 0);
    set_unit(4, 1'b1, 1'b1, 32'h0000_AAAA);
    step(); clr_units(); #1;
    chk("bb_acc_resp", accepted, 0);
    chk("bb_done1", done, 1);
    chk("bb_rd1", rd, 32'h0000_AAAA);
    chk("bb_urs1_stable", u_rs1, 32'hAAAA_0001);
    step(); #1;
    chk("bb_acc_idle", accepted, 1);
    step(); order = 1'b0; #1;
    chk("bb_uorder2", u_order, 6'b000001);
    chk("bb_urs1_2", u_rs1, 32'h1111_1111);
    chk("bb_urs2_2", u_rs2, 32'h2222_2222);
    chk("bb_ufunc3_2", u_func3, 3'b001);
    set_unit(0, 1'b1, 1'b1, 32'h3333_3333);
    step(); clr_units(); #1;
    chk("bb_done2", done, 1);
    chk("bb_rd2", rd, 32'h3333_3333);

    // reset in WAIT aborts with no done
    step(); #1;
    step(); req(5'b01011, 3'b000, 32'h4080_0000, 32'h0); #1;
    step(); order = 1'b0; #1;
    set_unit(3, 1'b1, 1'b0, 32'h0);
    step(); clr_units(); #1;
    chk("rw_busy_wait", busy, 1);
    rstn = 1'b0;
    order = 1'b1;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_done", done, 0);
    chk("rw_rd", rd, 0);
    chk("rw_err", err, 0);
    chk("rw_uorder", u_order, 0);
    chk("rw_urs1", u_rs1, 0);
    chk("rw_acc", accepted, 0);
    order = 1'b0;
    set_unit(3, 1'b0, 1'b1, 32'h4000_0000);
    step(); clr_units();
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rw_nodone_%0d", c), done, 0);
    end
    req(5'b10100, 3'b001, 32'h4000_0000, 32'h4000_0000); #1;
    chk("rw_acc2", accepted, 1);
    step(); order = 1'b0; #1;
    chk("rw_uorder2", u_order, 6'b010000);
    set_unit(4, 1'b1, 1'b1, 32'h0000_0001);
    step(); clr_units(); #1;
    chk("rw_done2", done, 1);
    chk("rw_rd2", rd, 32'h0000_0001);
    chk("rw_err2", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_dispatch.md
# fpu_dispatch

Front end of the FPU, between the core's execute stage and the individual FPU units (fadd/fsub, fmul, fdiv, fsqrt, fcomp, misc). It accepts one FP operation at a time from the core and latches the operands. It decodes funct5 to a unit, drives that unit's order/accepted/done handshake, captures the unit's result, and returns it to the core with a one-cycle done pulse. Combinational units such as fcomp, which raise done in the same cycle as order, are handled alongside multi-cycle units.

## Interface
- TIMEOUT, 255: maximum cycles in WAIT before forced error completion; 0 disables the watchdog.
- NUNIT, 6: number of unit slots; fixed at 6 for this revision.
- clk  in  1  clock; single clock domain. Reset is asynchronous and active-low.
- rstn  in  1  asynchronous active-low reset.
- order  in  1  core request; held high until accepted.
- accepted  out  1  request taken this cycle.
- done  out  1  one-cycle pulse; rd/err valid.
- rs1, rs2  in  32  operands.
- funct5  in  5  instr[31:27].
- func3  in  3  rounding mode / compare select.
- rd  out  32  result; holds until the next done.
- err  out  1  valid with done; illegal funct5 or timeout.
- busy  out  1  state != IDLE.
- u_order  out  NUNIT  one-hot unit request.
- u_accepted  in  NUNIT  per-unit accept.
- u_done  in  NUNIT  per-unit done.
- u_rs1, u_rs2  out  32  latched operands, broadcast to all units.
- u_func3  out  3  latched func3, broadcast.
- u_funct5  out  5  latched funct5, broadcast.
- u_rd  in  32*NUNIT  unit results; slot i is bits [32i+31:32i].

## Operation
- Unit map:
  - 0 ADD: 00000, 00001.
  - 1 MUL: 00010.
  - 2 DIV: 00011.
  - 3 SQRT: 01011.
  - 4 COMP: 10100.
  - 5 MISC: 00100, 00101, 11000, 11010, 11100, 11110.
  - Any other funct5 is illegal.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - accepted = order (combinational).
  - On order, latch rs1, rs2, func3, funct5 and the decoded index.
  - Legal funct5 -> ISSUE. Illegal -> RESP with rd=0, err=1.
- ISSUE:
  - u_order[idx]=1, all other bits 0.
  - Stay until u_accepted[idx].
  - If u_done[idx] is high in the accept cycle, capture u_rd[idx] -> RESP.
  - Otherwise -> WAIT and drop u_order.
- WAIT:
  - u_order=0; watchdog counter increments each cycle.
  - On u_done[idx], capture rd, err=0 -> RESP.
  - If the counter reaches TIMEOUT first, rd=0, err=1 -> RESP.
- RESP: done=1 for exactly one cycle -> IDLE.
- Only bit idx of u_accepted/u_done is examined; other units' strobes are ignored.
- Operand latches change only on accept, so u_rs1/u_rs2/u_func3/u_funct5 are stable from ISSUE through RESP.
- A new order arriving during RESP is not accepted that cycle; it is accepted in the following IDLE cycle.

## Timing
- Reset values:
  - state=IDLE; watchdog counter=0.
  - u_rs1/u_rs2/u_func3/u_funct5=0.
  - accepted=0, done=0, rd=0, err=0, busy=0, u_order=0.
- Reset during any state aborts the operation; no done is ever emitted for it.
- Latency, counted as cycles from accept (cycle 0) to the done cycle:
  - Combinational unit (done with accept): done at cycle 2.
  - Unit with done k cycles after its accept: done at cycle 2+k.
  - Illegal funct5: done at cycle 1.
- Throughput: at most one operation in flight; back-to-back combinational operations accept every 3 cycles.
- Watchdog: err timeout fires exactly when the counter reaches TIMEOUT, i.e. done at cycle 2+TIMEOUT after accept when the unit accepts in the cycle after accept.
- A u_done arriving in the same cycle the counter reaches TIMEOUT wins; the real result is returned with err=0.
- u_done in ISSUE without u_accepted is ignored.
- Counter width is $clog2(TIMEOUT+1); it clears on entry to WAIT.

## Structure
- Package fpu_pkg holds:
  - FUNCT5_* constants.
  - Unit index localparams U_ADD..U_MISC and NUNIT.
  - The state encoding.
- Sub-module fpu_decode: combinational funct5 -> {legal, idx[2:0]}; reused by the hazard logic.
- All sequential logic lives in fpu_dispatch.

## Test plan
- fle with rs1=0x3F800000, rs2=0x40000000, funct5=10100, func3=000; comp model returns done with accept and rd=1 -> done at cycle 2, rd=0x00000001, err=0, u_order=0b010000 during ISSUE.
- fmul model accepts after 2 stall cycles, then done 3 cycles later with rd=0x40C00000 -> u_order held through the stall, done at cycle 7, rd=0x40C00000.
- funct5=01111 -> accepted at cycle 0, done at cycle 1, rd=0, err=1, u_order never asserted.
- TIMEOUT=4, fdiv model never raises done -> done, err=1, rd=0 exactly when the counter hits 4. Repeat with u_done in that same cycle -> err=0 and the unit's rd is returned.
- Assert order again during RESP and busy -> accepted=0 until IDLE; the second operation completes with its own operands.
- Drop rstn during WAIT -> all outputs 0 immediately, no done; after release, the next order proceeds normally.
